// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame states,
// FIFO entry layout, prefix codes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // A valid frame carries an odd number of ones over data plus parity.
  function automatic logic odd_ones(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchronisers for the PS/2 lines, a FILTER_LEN-sample glitch filter
// on the clock line and a one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic dat,
  output logic fall
);

  logic                  clk_meta_r;
  logic                  clk_sync_r;
  logic                  dat_meta_r;
  logic                  dat_sync_r;
  logic [FILTER_LEN-1:0] hist_r;
  logic                  filt_r;
  logic                  fall_r;
  logic                  all_one_s;
  logic                  all_zero_s;

  assign all_one_s  = &hist_r;
  assign all_zero_s = ~|hist_r;

  // Synchronise both lines; idle bus level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk;
      clk_sync_r <= clk_meta_r;
      dat_meta_r <= ps2_dat;
      dat_sync_r <= dat_meta_r;
    end
  end

  // Level changes only once the whole sample history agrees.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_r <= '1;
      filt_r <= 1'b1;
      fall_r <= 1'b0;
    end else begin
      hist_r <= {hist_r[FILTER_LEN-2:0], clk_sync_r};
      fall_r <= filt_r & all_zero_s;
      if (all_one_s) begin
        filt_r <= 1'b1;
      end else if (all_zero_s) begin
        filt_r <= 1'b0;
      end else begin
        filt_r <= filt_r;
      end
    end
  end

  assign dat  = dat_sync_r;
  assign fall = fall_r;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame decode, E0/F0 prefix folding and scan-code FIFO.
// Define PS2_KBD_RX_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  output logic [7:0]                    out_code,
  output logic                          out_ext,
  output logic                          out_brk,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic                dat_s;
  logic                fall_s;
  ps2_state_e          state_r;
  logic [7:0]          shift_r;
  logic [2:0]          bit_cnt_r;
  logic                par_r;
  logic                ext_r;
  logic                brk_r;
  logic                push_r;
  ps2_entry_t          push_entry_r;
  logic                frame_err_r;
  logic                timeout_r;
  logic                to_hit_s;

  ps2_entry_t          mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;
  logic [AW:0]         count_nxt_s;
  logic                valid_r;
  logic                overflow_r;
  logic                pop_s;
  logic                full_s;
  logic                wr_en_s;
  ps2_entry_t          head_s;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (PS2_CLK),
    .ps2_dat (PS2_DAT),
    .dat     (dat_s),
    .fall    (fall_s)
  );

`ifdef PS2_KBD_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_r;

  // Cycles since the last filtered edge while a frame is in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_r <= '0;
    end else if (state_r == ST_IDLE || fall_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  assign to_hit_s = (state_r != ST_IDLE) && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit_s = 1'b0;
`endif

  // Frame FSM; result pulses and the push request are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      shift_r      <= 8'h00;
      bit_cnt_r    <= 3'd0;
      par_r        <= 1'b0;
      ext_r        <= 1'b0;
      brk_r        <= 1'b0;
      push_r       <= 1'b0;
      push_entry_r <= '0;
      frame_err_r  <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      push_r      <= 1'b0;
      frame_err_r <= 1'b0;
      timeout_r   <= 1'b0;
      if (fall_s) begin
        case (state_r)
          ST_IDLE: begin
            if (!dat_s) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_r   <= {dat_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_r   <= dat_s;
            state_r <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (odd_ones({shift_r, par_r}) && dat_s) begin
              if (shift_r == PS2_PFX_EXT) begin
                ext_r <= 1'b1;
              end else if (shift_r == PS2_PFX_BRK) begin
                brk_r <= 1'b1;
              end else begin
                push_r       <= 1'b1;
                push_entry_r <= '{ext: ext_r, brk: brk_r, code: shift_r};
                ext_r        <= 1'b0;
                brk_r        <= 1'b0;
              end
            end else begin
              frame_err_r <= 1'b1;
              ext_r       <= 1'b0;
              brk_r       <= 1'b0;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (to_hit_s) begin
        state_r   <= ST_IDLE;
        ext_r     <= 1'b0;
        brk_r     <= 1'b0;
        timeout_r <= 1'b1;
      end
    end
  end

  assign pop_s   = valid_r & out_ready;
  assign full_s  = (count_r == (AW+1)'(FIFO_DEPTH));
  assign wr_en_s = push_r & (~full_s | pop_s);

  // Occupancy after this cycle's accepted push and pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and status pulses; pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r    <= count_nxt_s;
      valid_r    <= (count_nxt_s != '0);
      overflow_r <= push_r & full_s & ~pop_s;
    end
  end

  // Entry storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_entry_r;
    end
  end

  assign head_s     = mem_r[rd_ptr_r];
  assign out_code   = head_s.code;
  assign out_ext    = head_s.ext;
  assign out_brk    = head_s.brk;
  assign out_valid  = valid_r;
  assign fifo_count = count_r;
  assign frame_err  = frame_err_r;
  assign overflow   = overflow_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: decode, prefixes, parity error, overflow,
// clock glitches, mid-frame reset and (with PS2_KBD_RX_TIMEOUT_EN) timeout.
module tb_ps2_kbd_rx;

  localparam int FL   = 8;
  localparam int FD   = 8;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_brk;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overflow;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;
  int ovf_seen = 0;
  int to_seen  = 0;
  int snap;

  ps2_kbd_rx #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .out_code   (out_code),
    .out_ext    (out_ext),
    .out_brk    (out_brk),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Pulse tallies.
  always @(posedge clk) begin
    if (frame_err) err_seen <= err_seen + 1;
    if (overflow)  ovf_seen <= ovf_seen + 1;
    if (timeout)   to_seen  <= to_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) PS2_DAT = b;
    repeat (HALF) @(negedge clk);
    PS2_CLK = 1'b0;
    repeat (HALF) @(negedge clk);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par);
    logic par;
    par = ~(^code) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
    send_bit(1'b1);
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    check({tag, "_code"}, 32'(out_code), 32'(code));
    check({tag, "_ext"},  32'(out_ext),  32'(ext));
    check({tag, "_brk"},  32'(out_brk),  32'(brk));
  endtask

  initial begin
    logic [7:0] c1c;
    reset     = 1'b0;
    PS2_CLK   = 1'b1;
    PS2_DAT   = 1'b1;
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_valid", 32'(out_valid),  32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ferr",  32'(frame_err),  32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);
    check("rst_to",    32'(timeout),    32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // 0x1C, parity 0: out_valid rises 13 cycles after the stop-bit clock falls.
    c1c = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(c1c[i]);
    send_bit(1'b0);
    @(negedge clk) PS2_DAT = 1'b1;
    repeat (HALF) @(negedge clk);
    PS2_CLK = 1'b0;
    repeat (12) @(negedge clk);
    check("valid_before", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("valid_rise", 32'(out_valid), 32'd1);
    repeat (HALF - 13) @(negedge clk);
    PS2_CLK = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check_head("h1c", 8'h1C, 1'b0, 1'b0);
    check("cnt_1c", 32'(fifo_count), 32'd1);
    pop_one();
    check("cnt_pop", 32'(fifo_count), 32'd0);
    check("valid_pop", 32'(out_valid), 32'd0);

    // E0 F0 75 fold into a single entry.
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    check("pfx_nopush", 32'(fifo_count), 32'd0);
    send_frame(8'h75, 1'b0);
    check("cnt_75", 32'(fifo_count), 32'd1);
    check_head("h75", 8'h75, 1'b1, 1'b1);
    pop_one();

    // Parity error clears a pending break prefix.
    snap = err_seen;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b1);
    check("ferr_pulses", 32'(err_seen - snap), 32'd1);
    check("ferr_nopush", 32'(fifo_count), 32'd0);
    send_frame(8'h1C, 1'b0);
    check_head("after_err", 8'h1C, 1'b0, 1'b0);
    pop_one();

    // Overflow: FD+1 codes with no consumer.
    snap = ovf_seen;
    for (int i = 0; i <= FD; i++) send_frame(8'h10 + 8'(i), 1'b0);
    check("ovf_pulses", 32'(ovf_seen - snap), 32'd1);
    check("ovf_count",  32'(fifo_count), 32'(FD));
    for (int i = 0; i < FD; i++) begin
      check("ovf_order", 32'(out_code), 32'(8'h10 + 8'(i)));
      pop_one();
    end
    check("ovf_drain", 32'(fifo_count), 32'd0);

    // Short clock glitches with data low must not start a frame.
    snap = err_seen;
    PS2_DAT = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) PS2_CLK = 1'b0;
      repeat (FL - 1) @(negedge clk);
      PS2_CLK = 1'b1;
      repeat (20) @(negedge clk);
    end
    PS2_DAT = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_err", 32'(err_seen - snap), 32'd0);
    check("glitch_cnt", 32'(fifo_count), 32'd0);
    send_frame(8'h2A, 1'b0);
    check_head("after_glitch", 8'h2A, 1'b0, 1'b0);
    pop_one();

    // Reset mid-frame discards the partial frame and stored codes.
    send_frame(8'h44, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("mrst_cnt",   32'(fifo_count), 32'd0);
    check("mrst_valid", 32'(out_valid),  32'd0);
    send_frame(8'h55, 1'b0);
    check("mrst_next_cnt", 32'(fifo_count), 32'd1);
    check_head("after_rst", 8'h55, 1'b0, 1'b0);
    pop_one();

`ifdef PS2_KBD_RX_TIMEOUT_EN
    snap = to_seen;
    send_frame(8'hF0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (TO + 100) @(negedge clk);
    check("to_pulses", 32'(to_seen - snap), 32'd1);
    snap = err_seen;
    send_frame(8'h33, 1'b0);
    check("to_next_err", 32'(err_seen - snap), 32'd0);
    check("to_next_cnt", 32'(fifo_count), 32'd1);
    check_head("after_to", 8'h33, 1'b0, 1'b0);
    pop_one();
`else
    check("to_never", 32'(to_seen), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
